// File: rtl/vend_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vend_controller: vending-machine control FSM (coin edge -> add, dispense/refund
// handshake). Optional inactivity refund with VEND_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module vend_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic tm,
  input  logic ack,
  output logic tc,
  output logic tw,
  output logic d,
  output logic refund,
  output logic coin_en
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_WAIT   = 3'd1,
    S_ADD    = 3'd2,
    S_DISP   = 3'd3,
    S_REFUND = 3'd4
  } state_t;

  state_t state, state_nx;
  logic   c_q;
  logic   pend, pend_nx;
  logic   coin_edge;
  logic   expired;

  assign coin_edge = c & ~c_q;

`ifdef VEND_TIMEOUT_EN
  logic             credit;
  logic [CNT_W-1:0] cnt;

  // Counter only runs while credit is held in WAIT; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          credit <= 1'b0;
          cnt    <= '0;
        end
        S_ADD: begin
          credit <= 1'b1;
          cnt    <= '0;
        end
        S_WAIT: begin
          if (credit && (cnt != '1)) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign expired = credit && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
  assign expired    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      c_q   <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      c_q   <= c;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    tc       = 1'b0;
    tw       = 1'b0;
    d        = 1'b0;
    refund   = 1'b0;
    coin_en  = 1'b0;
    case (state)
      S_INIT: begin
        tc       = 1'b1;
        pend_nx  = 1'b0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        coin_en = 1'b1;
        // Coins win over tm so every accepted coin is totalled first.
        if (coin_edge || pend) begin
          state_nx = S_ADD;
          pend_nx  = 1'b0;
        end else if (tm) begin
          state_nx = S_DISP;
        end else if (expired) begin
          state_nx = S_REFUND;
        end
      end
      S_ADD: begin
        tw       = 1'b1;
        coin_en  = 1'b1;
        if (coin_edge) pend_nx = 1'b1;
        state_nx = S_WAIT;
      end
      S_DISP: begin
        d = 1'b1;
        if (ack) state_nx = S_INIT;
      end
      S_REFUND: begin
`ifdef VEND_TIMEOUT_EN
        refund = 1'b1;
`endif
        if (ack) state_nx = S_INIT;
      end
      default: state_nx = S_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// tb_vend_controller: directed bench with a small accumulator/comparator
// datapath model driven by tc/tw.
module tb_vend_controller;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst, c, ack;
  logic       tm;
  logic       tc, tw, d, refund, coin_en;
  logic [7:0] a, s, total;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   tw_cnt = 0;
  int   tw_b2b = 0;
  int   d_rise = 0;
  logic tw_prev = 1'b0;
  logic d_prev = 1'b0;
  int   base_tw, base_d;
  logic seen, stayed;

  vend_controller #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .c      (c),
    .tm     (tm),
    .ack    (ack),
    .tc     (tc),
    .tw     (tw),
    .d      (d),
    .refund (refund),
    .coin_en(coin_en)
  );

  always #5 clk = ~clk;

  // Datapath: clear on tc, add coin value on tw, flag total >= price.
  assign tm = (total >= s);
  always @(posedge clk) begin
    if (tc) total <= 8'd0;
    else if (tw) total <= total + a;
  end

  always @(negedge clk) begin
    if (tw) tw_cnt <= tw_cnt + 1;
    if (tw && tw_prev) tw_b2b <= tw_b2b + 1;
    if (d && !d_prev) d_rise <= d_rise + 1;
    tw_prev <= tw;
    d_prev  <= d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [7:0] val, input int hi, input int lo);
    a = val;
    c = 1'b1;
    repeat (hi) tick();
    c = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; c = 1'b0; ack = 1'b0; a = 8'd0; s = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tc", tc, 1);
    check("rst_coin_en", coin_en, 0);
    check("rst_outs", {29'd0, tw, d, refund}, 0);
    rst = 1'b0;
    tick();
    check("wait_coin_en", coin_en, 1);
    check("wait_tc", tc, 0);
    check("total_clear", total, 0);

    // Coins 2, 2, 1 with c high 3 cycles each.
    insert(8'd2, 3, 2);
    insert(8'd2, 3, 2);
    check("total_4", total, 4);
    a = 8'd1; c = 1'b1;
    tick();
    check("c3_tw", tw, 1);
    check("c3_d_k", d, 0);
    tick();
    check("c3_d_k1", d, 0);
    check("total_5", total, 5);
    tick();
    check("d_rise", d, 1);
    check("disp_coin_en", coin_en, 0);
    c = 1'b0;
    tick();
    check("d_hold", d, 1);
    check("tw_count_3", tw_cnt, 3);
    check("tw_b2b_0", tw_b2b, 0);
    ack = 1'b1;
    tick();
    check("d_fall", d, 0);
    check("tc_pulse", tc, 1);
    ack = 1'b0;
    tick();
    check("tc_one_cycle", tc, 0);
    check("total_after_disp", total, 0);

    // Overpay with price 3, ack held 4 cycles.
    s = 8'd3; base_tw = tw_cnt; base_d = d_rise;
    a = 8'd5; c = 1'b1;
    repeat (3) tick();
    check("overpay_d", d, 1);
    c = 1'b0; ack = 1'b1;
    repeat (4) tick();
    ack = 1'b0;
    tick();
    check("overpay_d_low", d, 0);
    check("overpay_one_disp", d_rise - base_d, 1);
    check("overpay_one_tw", tw_cnt - base_tw, 1);

    // Back-to-back coins with one low cycle between them.
    s = 8'd5; base_tw = tw_cnt;
    a = 8'd2; c = 1'b1;
    tick();
    check("bb_tw1", tw, 1);
    c = 1'b0;
    tick();
    check("bb_gap", tw, 0);
    check("bb_gap_wait", coin_en, 1);
    a = 8'd1; c = 1'b1;
    tick();
    check("bb_tw2", tw, 1);
    c = 1'b0;
    tick();
    check("bb_total", total, 3);
    check("bb_tw_count", tw_cnt - base_tw, 2);
    check("bb_b2b", tw_b2b, 0);

    // Reset during dispense.
    a = 8'd2; c = 1'b1;
    tick();
    c = 1'b0;
    tick();
    tick();
    check("pre_rst_d", d, 1);
    rst = 1'b1;
    #1;
    check("async_d_drop", d, 0);
    check("async_tc", tc, 1);
    @(posedge clk);
    #1;
    check("rst_total_clear", total, 0);
    rst = 1'b0;
    tick();
    check("tm_after_rst", tm, 0);
    check("rst_back_wait", coin_en, 1);

`ifdef VEND_TIMEOUT_EN
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (refund) seen = 1'b1;
    end
    check("no_credit_no_refund", seen, 0);
    a = 8'd2; c = 1'b1;
    tick();
    c = 1'b0;
    tick();
    repeat (7) begin
      tick();
      if (refund) seen = 1'b1;
    end
    check("refund_not_early", seen, 0);
    tick();
    check("refund_at_8", refund, 1);
    check("refund_no_d", d, 0);
    ack = 1'b1;
    tick();
    check("refund_release", refund, 0);
    check("refund_tc", tc, 1);
    ack = 1'b0;
    tick();
    check("refund_total", total, 0);
`else
    a = 8'd2; c = 1'b1;
    tick();
    c = 1'b0;
    tick();
    seen = 1'b0; stayed = 1'b1;
    repeat (100) begin
      tick();
      if (refund) seen = 1'b1;
      if (!coin_en || tw || d) stayed = 1'b0;
    end
    check("no_timeout_refund", seen, 0);
    check("no_timeout_wait", stayed, 1);
    check("no_timeout_total", total, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
